alu_mp_seq: RTL and testbench
=============================

Name: alu_mp_seq

Overview:
- Multi-precision sequencer for the 8-bit ALU (ops 000 ADC, 001 SBB, 010 AND, 011 OR, 100 XOR, 101 NOT, 11x MOV).
- Runs one N-byte operation over register-file operands, one byte per cycle, least significant byte first.
- Drives the ALU op/ce_cy controls and the register-file read/write addresses, and chains carry/borrow through the ALU's own cy flop.
- Sits between the instruction decoder (command side) and the ALU plus register file.

Parameters:
- AW, 4, register-file address width; all address arithmetic wraps mod 2^AW.
- LEN_W, 4, width of cmd_len; max operation length is 2^LEN_W-1 bytes.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous reset, active low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE with rst_n high; a command is accepted on an edge where cmd_valid and cmd_ready are both high.
- cmd_op  in  3  ALU op applied to every byte.
- cmd_len  in  LEN_W  byte count; 0 is legal.
- cmd_chain  in  1  for ops 000/001: keep the current ALU cy and skip the carry-clear cycle.
- cmd_a_base, cmd_r_base, cmd_d_base  in  AW each  base addresses of operand A, operand R and the destination.
- alu_op  out  3  to ALU op.
- alu_ce_cy  out  1  to ALU ce_cy.
- alu_result  in  8  ALU result.
- alu_cy  in  1  ALU cy flop.
- ra_addr, rr_addr  out  AW each  register-file async read addresses, feeding ALU in_a and in_r.
- wd_addr  out  AW  register-file write address; write data is alu_result.
- wd_en  out  1  register-file synchronous write enable.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse in DONE.
- res_zero  out  1  1 if every result byte was 0x00.
- res_cy  out  1  final ALU cy.

Behaviour:
- Reset (rst_n low at an edge): state goes to IDLE, whether or not an operation is in progress. While rst_n is low and in the cycle after reset: cmd_ready=0, wd_en=0, alu_ce_cy=0, busy=0, done=0, res_zero=0, res_cy=0, alu_op=3'b110, all addresses 0.
- Reset mid-operation: bytes already written stay written. No further writes occur. The ALU cy value is undefined to the software.
- On accept, latch op, len, chain and the three bases; clear the byte index; set the zero accumulator to 1.
- States: IDLE, CLR, RUN, DONE.
  - IDLE -> CLR if op is 000/001, chain=0 and len!=0.
  - IDLE -> RUN if len!=0 otherwise.
  - IDLE -> DONE if len=0.
- CLR (1 cycle): alu_op=3'b010, alu_ce_cy=1, wd_en=0. The ALU cy becomes 0 at the edge. Next state RUN.
- RUN, byte i: alu_op=latched op, alu_ce_cy=1, wd_en=1.
  - ra_addr=a_base+i, rr_addr=r_base+i, wd_addr=d_base+i (wrapping).
  - Zero accumulator &= (alu_result==0).
  - Leave RUN after the edge where i=len-1, else increment i.
  - Carry from byte i is in alu_cy for byte i+1.
- Logic ops and MOV also assert alu_ce_cy in RUN, so the final cy is 0.
- DONE (1 cycle): done=1, busy=1, cmd_ready=0.
  - res_zero = accumulator (1 when len=0).
  - res_cy = alu_cy.
  - Both are valid in DONE and hold until the next accept. Next state IDLE.
- Outside CLR/RUN: alu_ce_cy=0 and wd_en=0.
- Latency, with accept at edge T:
  - arithmetic, non-chained: done in cycle T+len+2.
  - otherwise: done in cycle T+len+1.
  - len=0: done in cycle T+1, with no ALU or register-file activity.
  - cmd_ready returns the cycle after DONE. No back-to-back accept.
- Overlap: d_base==a_base or d_base==r_base (in-place) must give correct results. Any other partial overlap is undefined.
- cmd_* inputs are ignored while cmd_ready=0.

Test Plan:
1. Non-chained ADD: r0=FF, r1=00, r2=01, r3=00; accept op=000, len=2, a=0, r=2, d=4 at T -> CLR in T+1 with wd_en=0; writes r4=00, r5=01 at T+2 and T+3; done in T+4 with res_cy=0, res_zero=0.
2. Carry-out: FFFF+0001, len=2 -> r4=00, r5=00, res_cy=1, res_zero=1.
3. SUB borrow: 0100-0001 -> 00FF, res_cy=0; then 0000-0001 -> FFFF, res_cy=1.
4. Chain: after case 2 (cy=1), op=000, chain=1, len=1, A=10, R=20 -> no CLR cycle; result 31; done at T+2.
5. Logic and len=0: XOR, len=3, d=a in place -> in-place result correct, alu_ce_cy high in all 3 RUN cycles, res_cy=0. Then len=0 -> done at T+1, res_zero=1, wd_en never high.
6. Reset mid-op: len=4 ADD, rst_n low during RUN byte 1 -> next cycle busy=0, wd_en=0, done=0; only byte 0 (and byte 1 if its edge was not the reset edge) written; cmd_ready=1 once rst_n is high; a new command then completes normally.

Source files
------------

// File: rtl/alu_mp_seq.sv
// alu_mp_seq: sequences one N-byte ALU operation over register-file operands, LSB first,
// chaining carry/borrow through the ALU's own cy flop.
module alu_mp_seq #(
  parameter int AW    = 4,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_chain,
  input  logic [AW-1:0]    cmd_a_base,
  input  logic [AW-1:0]    cmd_r_base,
  input  logic [AW-1:0]    cmd_d_base,
  output logic [2:0]       alu_op,
  output logic             alu_ce_cy,
  input  logic [7:0]       alu_result,
  input  logic             alu_cy,
  output logic [AW-1:0]    ra_addr,
  output logic [AW-1:0]    rr_addr,
  output logic [AW-1:0]    wd_addr,
  output logic             wd_en,
  output logic             busy,
  output logic             done,
  output logic             res_zero,
  output logic             res_cy
);
  typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d;
  logic [AW-1:0] a_q, a_d, r_q, r_d, d_q, d_d, idx_w;
  logic zacc_q, zacc_d, cy_q, cy_d;
  logic run, clr;
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    len_d   = len_q;
    idx_d   = idx_q;
    a_d     = a_q;
    r_d     = r_q;
    d_d     = d_q;
    zacc_d  = zacc_q;
    cy_d    = cy_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        op_d    = cmd_op;
        len_d   = cmd_len;
        a_d     = cmd_a_base;
        r_d     = cmd_r_base;
        d_d     = cmd_d_base;
        idx_d   = '0;
        zacc_d  = 1'b1;
        // Non-chained ADC/SBB need one AND cycle first to force the ALU cy to 0.
        state_d = (cmd_len == '0) ? DONE :
                  (cmd_op[2:1] == 2'b00 && !cmd_chain) ? CLR : RUN;
      end
      CLR: state_d = RUN;
      RUN: begin
        zacc_d  = zacc_q & (alu_result == 8'h00);
        idx_d   = idx_q + 1'b1;
        state_d = (idx_q == len_q - 1'b1) ? DONE : RUN;
      end
      DONE: begin
        cy_d    = alu_cy;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      a_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      zacc_q  <= 1'b0;
      cy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      r_q     <= r_d;
      d_q     <= d_d;
      zacc_q  <= zacc_d;
      cy_q    <= cy_d;
    end
  end
  // Every control output is gated by rst_n so reset values show while rst_n is held low.
  assign run       = rst_n && state_q == RUN;
  assign clr       = rst_n && state_q == CLR;
  assign idx_w     = AW'(idx_q);
  assign alu_op    = run ? op_q : clr ? 3'b010 : 3'b110;
  assign alu_ce_cy = run | clr;
  assign wd_en     = run;
  assign ra_addr   = run ? a_q + idx_w : '0;
  assign rr_addr   = run ? r_q + idx_w : '0;
  assign wd_addr   = run ? d_q + idx_w : '0;
  assign cmd_ready = rst_n && state_q == IDLE;
  assign busy      = rst_n && state_q != IDLE;
  assign done      = rst_n && state_q == DONE;
  assign res_zero  = rst_n & zacc_q;
  assign res_cy    = rst_n & (done ? alu_cy : cy_q);
endmodule

// File: tb/tb_alu_mp_seq.sv
// tb_alu_mp_seq: drives alu_mp_seq against a behavioural ALU and register file and
// scoreboards every register write and every completion.
module tb_alu_mp_seq;
  logic clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, cmd_ready, cmd_chain = 1'b0;
  logic [2:0] cmd_op = '0, alu_op;
  logic [3:0] cmd_len = '0, cmd_a_base = '0, cmd_r_base = '0, cmd_d_base = '0;
  logic alu_ce_cy, alu_cy, wd_en, busy, done, res_zero, res_cy;
  logic [7:0] alu_result;
  logic [8:0] alu_s;
  logic [3:0] ra_addr, rr_addr, wd_addr;
  logic [7:0] rf [16];
  typedef struct {logic [3:0] addr; logic [7:0] data;} wr_t;
  typedef struct {logic z; logic c; int cyc;} dn_t;
  wr_t wq[$];
  dn_t dq[$];
  wr_t mw;
  dn_t md;
  int cyc = 0, checks = 0, errors = 0, wr_cnt = 0;
  logic model_cy = 1'b0;

  always #5 clk = ~clk;

  alu_mp_seq #(.AW(4), .LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_chain(cmd_chain),
    .cmd_a_base(cmd_a_base), .cmd_r_base(cmd_r_base), .cmd_d_base(cmd_d_base),
    .alu_op(alu_op), .alu_ce_cy(alu_ce_cy), .alu_result(alu_result), .alu_cy(alu_cy),
    .ra_addr(ra_addr), .rr_addr(rr_addr), .wd_addr(wd_addr), .wd_en(wd_en),
    .busy(busy), .done(done), .res_zero(res_zero), .res_cy(res_cy)
  );

  function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] a, r, input logic c);
    return op == 3'b000 ? {1'b0, a} + {1'b0, r} + {8'h00, c} :
           op == 3'b001 ? {1'b0, a} - {1'b0, r} - {8'h00, c} :
           op == 3'b010 ? {1'b0, a & r} :
           op == 3'b011 ? {1'b0, a | r} :
           op == 3'b100 ? {1'b0, a ^ r} :
           op == 3'b101 ? {1'b0, ~a} : {1'b0, a};
  endfunction

  assign alu_s      = alu_f(alu_op, rf[ra_addr], rf[rr_addr], alu_cy);
  assign alu_result = alu_s[7:0];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wd_en) rf[wd_addr] <= alu_result;
    if (alu_ce_cy) alu_cy <= alu_s[8];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wd_en) begin
      wr_cnt++;
      if (wq.size() == 0) check("unexpected_write", 1, 0);
      else begin
        mw = wq.pop_front();
        check("wr_addr", wd_addr, mw.addr);
        check("wr_data", alu_result, mw.data);
        check("run_ce_cy", alu_ce_cy, 1);
      end
    end
    if (done) begin
      if (dq.size() == 0) check("unexpected_done", 1, 0);
      else begin
        md = dq.pop_front();
        check("res_zero", res_zero, md.z);
        check("res_cy", res_cy, md.c);
        check("done_cycle", cyc, md.cyc);
        check("done_flags", {busy, cmd_ready}, 2'b10);
      end
    end
  end

  task automatic predict(input logic [2:0] op, input logic [3:0] len, input logic ch, input logic [3:0] a, r, d);
    logic c, z, clr;
    logic [8:0] s;
    logic [3:0] k;
    clr = op[2:1] == 2'b00 && !ch && len != 0;
    c = clr ? 1'b0 : model_cy;
    z = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i < int'(len)) begin
        k = 4'(i);
        s = alu_f(op, rf[a + k], rf[r + k], c);
        c = s[8];
        z &= s[7:0] == 8'h00;
        wq.push_back('{d + k, s[7:0]});
      end
    end
    dq.push_back('{z, c, cyc + int'(len) + int'(clr)});
    model_cy = c;
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] len, input logic ch, input logic [3:0] a, r, d, input bit sb);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("ready_timeout", 0, 1);
    {cmd_op, cmd_len, cmd_chain, cmd_a_base, cmd_r_base, cmd_d_base} = {op, len, ch, a, r, d};
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    if (sb) predict(op, len, ch, a, r, d);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) check("done_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [3:0] len, input logic ch, input logic [3:0] a, r, d);
    issue(op, len, ch, a, r, d, 1'b1);
    wait_done();
  endtask

  initial begin
    logic [8:0] s;
    int w0;
    alu_cy = 1'b0;
    for (int i = 0; i < 16; i++) rf[i] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {cmd_ready, busy, done, wd_en, alu_ce_cy, res_zero, res_cy}, 7'b0);
    check("rst_op", alu_op, 3'b110);
    check("rst_addr", {ra_addr, rr_addr, wd_addr}, 12'h000);
    rst_n = 1'b1;
    #1 check("ready_after_rst", cmd_ready, 1);
    check("idle_res", {res_zero, res_cy, busy}, 3'b000);
    // non-chained ADD with an explicit CLR-cycle check
    {rf[0], rf[1], rf[2], rf[3]} = {8'hFF, 8'h00, 8'h01, 8'h00};
    issue(3'b000, 4'd2, 1'b0, 4'd0, 4'd2, 4'd4, 1'b1);
    @(negedge clk);
    check("clr_cycle", {alu_op, alu_ce_cy, wd_en, busy}, {3'b010, 1'b1, 1'b0, 1'b1});
    wait_done();
    check("t1_r4r5", {rf[5], rf[4]}, 16'h0100);
    // carry out, then chained add consuming cy=1
    {rf[0], rf[1], rf[2], rf[3]} = {8'hFF, 8'hFF, 8'h01, 8'h00};
    run_cmd(3'b000, 4'd2, 1'b0, 4'd0, 4'd2, 4'd4);
    check("t2_r4r5", {rf[5], rf[4]}, 16'h0000);
    {rf[6], rf[7]} = {8'h10, 8'h20};
    run_cmd(3'b000, 4'd1, 1'b1, 4'd6, 4'd7, 4'd8);
    check("t4_r8", rf[8], 8'h31);
    // borrow
    {rf[0], rf[1], rf[2], rf[3]} = {8'h00, 8'h01, 8'h01, 8'h00};
    run_cmd(3'b001, 4'd2, 1'b0, 4'd0, 4'd2, 4'd4);
    check("t3a", {rf[5], rf[4]}, 16'h00FF);
    {rf[0], rf[1]} = {8'h00, 8'h00};
    run_cmd(3'b001, 4'd2, 1'b0, 4'd0, 4'd2, 4'd4);
    check("t3b", {rf[5], rf[4]}, 16'hFFFF);
    // in-place XOR, then zero length
    {rf[10], rf[11], rf[12], rf[13], rf[14], rf[15]} = {8'h5A, 8'h0F, 8'h81, 8'hA5, 8'h0F, 8'h7E};
    run_cmd(3'b100, 4'd3, 1'b0, 4'd10, 4'd13, 4'd10);
    check("t5_xor", {rf[12], rf[11], rf[10]}, 24'hFF00FF);
    w0 = wr_cnt;
    run_cmd(3'b000, 4'd0, 1'b0, 4'd1, 4'd2, 4'd3);
    check("len0_no_write", wr_cnt, w0);
    // wrapping addresses
    run_cmd(3'b000, 4'd4, 1'b0, 4'd14, 4'd6, 4'd2);
    // random in-place mix with operand R in the opposite half of the file
    for (int i = 0; i < 16; i++) rf[i] = 8'($urandom);
    for (int t = 0; t < 12; t++) begin
      logic [3:0] a;
      a = 4'($urandom_range(0, 15));
      run_cmd(3'($urandom_range(0, 7)), 4'($urandom_range(0, 8)), 1'($urandom_range(0, 1)), a, a + 4'd8, a);
    end
    run_cmd(3'b101, 4'd15, 1'b0, 4'd0, 4'd0, 4'd0);
    // reset during RUN byte 1
    {rf[0], rf[2], rf[9], rf[10], rf[11]} = {8'h12, 8'h34, 8'h5A, 8'h5A, 8'h5A};
    issue(3'b000, 4'd4, 1'b0, 4'd0, 4'd2, 4'd8, 1'b0);
    s = alu_f(3'b000, rf[0], rf[2], 1'b0);
    wq.push_back('{4'd8, s[7:0]});
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("rst_low_gate", {wd_en, busy, done, alu_ce_cy}, 4'b0000);
    @(posedge clk);
    @(negedge clk);
    check("post_rst", {busy, wd_en, done, cmd_ready}, 4'b0000);
    rst_n = 1'b1;
    #1 check("post_rst_ready", cmd_ready, 1);
    check("rst_byte0", rf[8], 8'h46);
    check("rst_no_more", {rf[9], rf[10], rf[11]}, 24'h5A5A5A);
    {rf[0], rf[1], rf[2], rf[3]} = {8'h80, 8'h01, 8'h80, 8'h02};
    run_cmd(3'b000, 4'd2, 1'b0, 4'd0, 4'd2, 4'd4);
    check("after_rst_cmd", {rf[5], rf[4]}, 16'h0400);
    check("wq_empty", wq.size(), 0);
    check("dq_empty", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
